// File: rtl/regfile_wb_arb.sv
// Write-back arbiter: two one-entry slots (ALU on A, LSU on B) share the register file's write port.
// Define WB_ARB_RR_EN for round-robin between different-address slots; otherwise A has fixed priority.
module regfile_wb_arb #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_data,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [DEPTH-1:0] pend_mask,
  output logic             busy
);

  localparam logic [DEPTH-1:0] BIT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  logic             a_full;
  logic [AW-1:0]    a_addr_q;
  logic [WIDTH-1:0] a_data_q;
  logic             b_full;
  logic [AW-1:0]    b_addr_q;
  logic [WIDTH-1:0] b_data_q;
  logic             a_older;

  logic gnt_a;
  logic gnt_b;
  logic pick_a;
  logic diff_pick_a;
  logic a_acc;
  logic b_acc;
  logic a_load;
  logic b_load;

`ifdef WB_ARB_RR_EN
  logic last_b;

  // Pointer remembers the most recently granted port; the other one wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (gnt_a || gnt_b) begin
      last_b <= gnt_b;
    end
  end

  assign diff_pick_a = last_b;
`else
  assign diff_pick_a = 1'b1;
`endif

  always_comb begin
    gnt_a  = 1'b0;
    gnt_b  = 1'b0;
    pick_a = 1'b0;
    if (a_full && b_full) begin
      // Same destination: the older slot goes first so the youngest value lands last.
      pick_a = (a_addr_q == b_addr_q) ? a_older : diff_pick_a;
      gnt_a  = pick_a;
      gnt_b  = !pick_a;
    end else begin
      gnt_a = a_full;
      gnt_b = b_full;
    end
  end

  assign a_ready = !a_full || gnt_a;
  assign b_ready = !b_full || gnt_b;
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;
  assign a_load  = a_acc && (a_addr != '0);
  assign b_load  = b_acc && (b_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full   <= 1'b0;
      a_addr_q <= '0;
      a_data_q <= '0;
    end else if (a_load) begin
      a_full   <= 1'b1;
      a_addr_q <= a_addr;
      a_data_q <= a_data;
    end else if (gnt_a) begin
      a_full   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_full   <= 1'b0;
      b_addr_q <= '0;
      b_data_q <= '0;
    end else if (b_load) begin
      b_full   <= 1'b1;
      b_addr_q <= b_addr;
      b_data_q <= b_data;
    end else if (gnt_b) begin
      b_full   <= 1'b0;
    end
  end

  // a_older=1 means A was loaded first; a same-edge double load counts A as older.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_older <= 1'b1;
    end else if (b_load) begin
      a_older <= 1'b1;
    end else if (a_load) begin
      a_older <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (gnt_a) begin
      rf_we    <= 1'b1;
      rf_waddr <= a_addr_q;
      rf_wdata <= a_data_q;
    end else if (gnt_b) begin
      rf_we    <= 1'b1;
      rf_waddr <= b_addr_q;
      rf_wdata <= b_data_q;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign pend_mask = ({DEPTH{a_full}} & (BIT0 << a_addr_q))
                   | ({DEPTH{b_full}} & (BIT0 << b_addr_q))
                   | ({DEPTH{rf_we}}  & (BIT0 << rf_waddr));

  assign busy = a_full || b_full || rf_we;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed vector table, contention/reset sequences, and a randomized scoreboard run.
module tb_regfile_wb_arb;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic        busy;

  regfile_wb_arb dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs [15];
  int n_checks;
  int n_fail;

  wr_t         qa[$];
  wr_t         qb[$];
  int          pend_cnt [32];
  logic [31:0] model_final [32];
  logic [31:0] tb_rf [32];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
  endtask

  task automatic drive_idle();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  // One randomized cycle: check mask and commit at negedge, update the reference at the edge.
  task automatic run_cycle(input bit allow_new);
    logic        acc_a;
    logic        acc_b;
    logic        did_commit;
    logic [4:0]  c_addr;
    logic [31:0] exp_mask;
    bit          found;
    @(negedge clk);
    exp_mask = '0;
    for (int i = 0; i < 32; i++) if (pend_cnt[i] != 0) exp_mask[i] = 1'b1;
    checkOutput("rand_pend_mask", 64'(pend_mask), 64'(exp_mask));
    did_commit = rf_we;
    c_addr = rf_waddr;
    if (rf_we) begin
      found = 1'b0;
      if (qa.size() > 0 && qa[0].addr == rf_waddr && qa[0].data == rf_wdata) begin
        void'(qa.pop_front()); found = 1'b1;
      end else if (qb.size() > 0 && qb[0].addr == rf_waddr && qb[0].data == rf_wdata) begin
        void'(qb.pop_front()); found = 1'b1;
      end
      checkOutput("rand_commit_match", 64'(found), 64'd1);
      tb_rf[rf_waddr] = rf_wdata;
    end
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    @(posedge clk);
    if (did_commit) pend_cnt[c_addr]--;
    if (acc_a && a_addr != 5'd0) begin
      qa.push_back('{a_addr, a_data}); pend_cnt[a_addr]++; model_final[a_addr] = a_data;
    end
    if (acc_b && b_addr != 5'd0) begin
      qb.push_back('{b_addr, b_data}); pend_cnt[b_addr]++; model_final[b_addr] = b_data;
    end
    #1;
    if (!(a_valid && !acc_a)) begin
      a_valid = allow_new && ($urandom_range(0, 2) != 0);
      a_addr  = 5'($urandom_range(0, 7));
      a_data  = $urandom;
    end
    if (!(b_valid && !acc_b)) begin
      b_valid = allow_new && ($urandom_range(0, 2) != 0);
      b_addr  = 5'($urandom_range(0, 7));
      b_data  = $urandom;
    end
  endtask

  initial begin
    logic        acc_a;
    logic        acc_b;
    int          ka;
    int          kb;
    int          guard;
    logic [4:0]  cw_addr[$];
    logic [31:0] cw_data[$];
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive_idle();

    // Columns: A(v,addr,data) B(v,addr,data) | a_ready b_ready rf_we rf_waddr rf_wdata pend_mask
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0000_0020};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0000_0020};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1'b1, 5'd7, 32'h1,        1'b1, 5'd7, 32'h2,   1'b1, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0000_0080};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b1, 5'd7,  32'h1,        32'h0000_0080};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b1, 5'd7,  32'h2,        32'h0000_0080};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b0, 5'd7,  32'h2,        32'h0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'h100, 1'b1, 1'b1, 1'b0, 5'd7,  32'h2,        32'h0000_0400};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd11, 32'h101, 1'b1, 1'b1, 1'b1, 5'd10, 32'h100,      32'h0000_0C00};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'h102, 1'b1, 1'b1, 1'b1, 5'd11, 32'h101,      32'h0000_1800};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd13, 32'h103, 1'b1, 1'b1, 1'b1, 5'd12, 32'h102,      32'h0000_3000};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b1, 5'd13, 32'h103,      32'h0000_2000};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 1'b1, 1'b0, 5'd13, 32'h103,      32'h0};

    #2;
    checkOutput("reset_rf_we",    64'(rf_we),     64'd0);
    checkOutput("reset_waddr",    64'(rf_waddr),  64'd0);
    checkOutput("reset_wdata",    64'(rf_wdata),  64'd0);
    checkOutput("reset_pend",     64'(pend_mask), 64'd0);
    checkOutput("reset_a_ready",  64'(a_ready),   64'd1);
    checkOutput("reset_b_ready",  64'(b_ready),   64'd1);
    checkOutput("reset_busy",     64'(busy),      64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_a_ready", i), 64'(a_ready),   64'(vecs[i].e_ar));
      checkOutput($sformatf("vec%0d_b_ready", i), 64'(b_ready),   64'(vecs[i].e_br));
      checkOutput($sformatf("vec%0d_rf_we", i),   64'(rf_we),     64'(vecs[i].e_we));
      checkOutput($sformatf("vec%0d_waddr", i),   64'(rf_waddr),  64'(vecs[i].e_wa));
      checkOutput($sformatf("vec%0d_wdata", i),   64'(rf_wdata),  64'(vecs[i].e_wd));
      checkOutput($sformatf("vec%0d_pend", i),    64'(pend_mask), 64'(vecs[i].e_pend));
    end
    drive_idle();

    // Both ports stream to different registers; the producers advance only on a handshake.
    ka = 0; kb = 0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA000_0000;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB000_0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      if (rf_we) begin
        cw_addr.push_back(rf_waddr);
        cw_data.push_back(rf_wdata);
      end
      @(posedge clk); #1;
      if (acc_a) begin ka++; a_data = 32'hA000_0000 + 32'(ka); end
      if (acc_b) begin kb++; b_data = 32'hB000_0000 + 32'(kb); end
    end
    checkOutput("stream_commit_count", 64'(cw_addr.size() >= 8), 64'd1);
    for (int k = 0; k < 8; k++) begin
`ifdef WB_ARB_RR_EN
      e_addr = (k % 2 == 0) ? 5'd1 : 5'd2;
      e_data = (k % 2 == 0) ? 32'hA000_0000 + 32'(k / 2) : 32'hB000_0000 + 32'(k / 2);
`else
      e_addr = 5'd1;
      e_data = 32'hA000_0000 + 32'(k);
`endif
      if (k < cw_addr.size()) begin
        checkOutput($sformatf("stream%0d_addr", k), 64'(cw_addr[k]), 64'(e_addr));
        checkOutput($sformatf("stream%0d_data", k), 64'(cw_data[k]), 64'(e_data));
      end
    end
`ifdef WB_ARB_RR_EN
    checkOutput("stream_b_progress", 64'(kb >= 4), 64'd1);
`else
    checkOutput("stream_b_starved", 64'(kb), 64'd1);
`endif
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Mid-cycle reset with a write in flight and a slot full.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    @(posedge clk); #1;
    a_addr = 5'd4; a_data = 32'h44;
    @(posedge clk); #1;
    a_valid = 1'b0;
    checkOutput("midrst_pre_we",   64'(rf_we),     64'd1);
    checkOutput("midrst_pre_pend", 64'(pend_mask), 64'h18);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_rf_we",   64'(rf_we),     64'd0);
    checkOutput("midrst_pend",    64'(pend_mask), 64'd0);
    checkOutput("midrst_a_ready", 64'(a_ready),   64'd1);
    checkOutput("midrst_b_ready", 64'(b_ready),   64'd1);
    checkOutput("midrst_busy",    64'(busy),      64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postrst_rf_we", 64'(rf_we),     64'd0);
    checkOutput("postrst_pend",  64'(pend_mask), 64'd0);

    for (int i = 0; i < 32; i++) begin
      pend_cnt[i] = 0; model_final[i] = '0; tb_rf[i] = '0;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int c = 0; c < 400; c++) run_cycle(1'b1);
    guard = 0;
    while ((busy || qa.size() != 0 || qb.size() != 0 || a_valid || b_valid) && guard < 60) begin
      run_cycle(1'b0);
      guard++;
    end
    checkOutput("drain_in_budget", 64'(guard < 60), 64'd1);
    checkOutput("drain_busy",      64'(busy),       64'd0);
    checkOutput("drain_qa_empty",  64'(qa.size()),  64'd0);
    checkOutput("drain_qb_empty",  64'(qb.size()),  64'd0);
    for (int i = 1; i < 32; i++)
      checkOutput($sformatf("final_x%0d", i), 64'(tb_rf[i]), 64'(model_final[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
